// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector,
// FSM encodings, queue entry layout and PC increment helper.
package fetch_unit_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0]  S_FETCH = 2'd0;
    localparam logic [1:0]  S_FULL  = 2'd1;
    localparam logic [1:0]  S_DROP  = 2'd2;

    typedef struct packed {
        logic [31:0]            pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Sequential next PC; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's PC-register, imem and decode-side signals.
// master = fetch unit, slave = the surrounding pipeline / memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [31:0]            pc;
    logic [31:0]            newPC;
    logic                   redirect;
    logic [31:0]            redirectTarget;
    logic                   imemReq;
    logic [31:0]            imemAddr;
    logic                   imemAck;
    logic [INSTR_WIDTH-1:0] imemRdata;
    logic                   instValid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [31:0]            instPC;
    logic                   instReady;

    modport master (
        input  pc, redirect, redirectTarget, imemAck, imemRdata, instReady,
        output newPC, imemReq, imemAddr, instValid, instr, instPC
    );

    modport slave (
        output pc, redirect, redirectTarget, imemAck, imemRdata, instReady,
        input  newPC, imemReq, imemAddr, instValid, instr, instPC
    );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Two-entry fetch queue of {pc, instr}. slot0 is always the head; when the
// queue drains, slot0 is left untouched so the head outputs hold their
// last value.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         pop_eff;
    logic [1:0]   push_w;
    logic [1:0]   pop_w;

    // A pop against an empty queue is a no-op.
    always_comb begin
        pop_eff = pop && (count != 2'd0);
        push_w  = {1'b0, push};
        pop_w   = {1'b0, pop_eff};
    end

    assign head = slot0;

    // Occupancy and slot storage; flush empties the queue and drops any push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count + push_w - pop_w;
            if (pop_eff && (count == 2'd2)) begin
                slot0 <= slot1;
            end
            if (push) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop_eff)) begin
                    slot0 <= din;
                end else if (count == 2'd1) begin
                    slot1 <= din;
                end else if ((count == 2'd2) && pop_eff) begin
                    slot1 <= din;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives newPC into the external PC register,
// runs the imem req/ack handshake and feeds decode through fetch_buffer.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_FETCH | requesting imem at pc; ack without redirect pushes a word
//  S_FULL  | queue holds two entries, no request issued
//  S_DROP  | redirected mid-read; hold dropAddr until the stale ack
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [31:0]  drop_addr;
    logic [31:0]  drop_addr_nxt;

    logic         accept;
    logic         push;
    logic         pop;
    logic         flush;
    logic [1:0]   count;
    logic [1:0]   post_cnt;
    fetch_entry_t din;
    fetch_entry_t head;

    // Handshake decode; reset masks every event so nothing leaks into state.
    always_comb begin
        accept   = rst_n && (state == S_FETCH) && bus.imemAck && !bus.redirect;
        push     = accept;
        pop      = (count != 2'd0) && bus.instReady;
        flush    = rst_n && bus.redirect;
        post_cnt = count + {1'b0, push} - {1'b0, pop};
        din.pc    = bus.pc;
        din.instr = bus.imemRdata;
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .count (count),
        .head  (head)
    );

    // Next-PC select for the PC register; an ack while dropping never advances.
    always_comb begin
        if (!rst_n) begin
            bus.newPC = RESET_PC;
        end else if (bus.redirect) begin
            bus.newPC = bus.redirectTarget;
        end else if (accept) begin
            bus.newPC = pc_plus4(bus.pc);
        end else begin
            bus.newPC = bus.pc;
        end
    end

    // Request/address outputs; the address is frozen on dropAddr in S_DROP.
    always_comb begin
        bus.imemReq  = 1'b0;
        bus.imemAddr = 32'd0;
        if (rst_n) begin
            if (state == S_FETCH) begin
                bus.imemReq  = 1'b1;
                bus.imemAddr = bus.pc;
            end else if (state == S_DROP) begin
                bus.imemReq  = 1'b1;
                bus.imemAddr = drop_addr;
            end
        end
    end

    assign bus.instValid = (count != 2'd0);
    assign bus.instr     = head.instr;
    assign bus.instPC    = head.pc;

    // FSM next-state, in priority order per state.
    always_comb begin
        state_nxt     = state;
        drop_addr_nxt = drop_addr;
        case (state)
            S_FETCH: begin
                if (bus.redirect && !bus.imemAck) begin
                    state_nxt     = S_DROP;
                    drop_addr_nxt = bus.pc;
                end else if (bus.redirect) begin
                    state_nxt = S_FETCH;
                end else if (accept && (post_cnt == 2'd2)) begin
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.redirect || pop) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (bus.imemAck) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            drop_addr <= 32'd0;
        end else begin
            state     <= state_nxt;
            drop_addr <= drop_addr_nxt;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage wrapped around the PC register.
- Computes `newPC` for the PC register, which loads on the falling clock edge.
- Issues instruction-memory reads at the current `pc` using a req/ack handshake with variable latency.
- Buffers fetched words in a 2-entry queue that feeds the decode stage.
- Absorbs branch/jump redirects, including redirects that arrive while a memory read is still outstanding.

Parameters:
- RESET_PC, 32'h0000_3000: reset vector driven on `newPC` while in reset.
- BUF_DEPTH, 2: fetch-queue depth. This is fixed at 2; other values are unsupported.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- pc, input, 32: current PC from the PC register.
- newPC, output, 32: next PC to the PC register, combinational.
- redirect, input, 1: branch/jump taken this cycle, from resolution logic.
- redirectTarget, input, 32: redirect destination.
- imemReq, output, 1: read request.
- imemAddr, output, 32: read address.
- imemAck, input, 1: one-cycle read-complete strobe.
- imemRdata, input, 32: read data, valid when `imemAck`=1.
- instValid, output, 1: queue head is valid.
- instr, output, 32: queue head instruction.
- instPC, output, 32: PC of the queue head.
- instReady, input, 1: decode accepts the head this cycle.

Behaviour:
- Reset (`rst_n`=0 at a rising edge):
  - Next cycle: state=S_FETCH, count=0, `instValid`=0, `instr`=0, `instPC`=0, `imemReq`=0, `imemAddr`=0.
  - `newPC`=RESET_PC combinationally while `rst_n`=0.
  - `rst_n` must stay low for at least one full clock period, so that the PC register captures RESET_PC on a falling edge.
  - Reset overrides every other event, including an outstanding read; imem shares the same `rst_n`.
- Memory handshake:
  - `imemReq` stays high with a constant `imemAddr` until `imemAck`; a request is never withdrawn.
  - `imemAck` may arrive in the same cycle as `imemReq` rises (zero wait).
  - At most one read is outstanding.
- States:
  - S_FETCH: `imemReq`=1, `imemAddr`=`pc`.
  - S_FULL: `imemReq`=0 because the queue is full.
  - S_DROP: `imemReq`=1, `imemAddr`=dropAddr (latched). A stale read is in flight and its data will be discarded.
- Accept: a cycle in S_FETCH with `imemAck`=1 and `redirect`=0. The effect is to push {`pc`, `imemRdata`} into the queue.
- Transitions, evaluated in priority order (reset first):
  - S_FETCH, `redirect`=1, `imemAck`=0: go to S_DROP and latch dropAddr=`pc`.
  - S_FETCH, `redirect`=1, `imemAck`=1: discard the data and stay in S_FETCH.
  - S_FETCH, accept: go to S_FULL if the post-push/pop count is 2, otherwise stay in S_FETCH.
  - S_FULL, `redirect`=1: go to S_FETCH.
  - S_FULL, pop: go to S_FETCH.
  - S_DROP, `imemAck`=1: discard the data and go to S_FETCH, regardless of `redirect`.
  - S_DROP, `imemAck`=0: stay in S_DROP.
- `newPC` (combinational, not in reset):
  - `redirect`=1: `newPC`=`redirectTarget`.
  - accept: `newPC`=`pc`+4, with 32-bit wrap (0xFFFF_FFFC goes to 0).
  - otherwise: `newPC`=`pc`.
  - An ack in S_DROP never advances the PC.
- Queue:
  - Pop condition: `instValid` && `instReady`.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pop when empty is ignored.
  - A push at count=2 cannot occur.
  - `instr`/`instPC` hold the head entry. When the queue is empty they keep their last value.
- Redirect flush:
  - `redirect`=1 sets count to 0 on the next edge, dropping queued entries and any same-cycle push.
  - A same-cycle pop is still a valid handoff.
  - `instValid`=0 in the following cycle.
- Latency: with zero-wait memory and `instReady`=1, one instruction per cycle. An instruction fetched in cycle N is on `instr` in cycle N+1.

Decomposition:
- Shared package holds:
  - RESET_PC default.
  - State encodings S_FETCH/S_FULL/S_DROP as 2-bit localparams.
  - INSTR_WIDTH=32.
- Sub-module fetch_buffer: 2-entry synchronous FIFO of {pc[31:0], instr[31:0]}.
  - Ports: push, pop, flush, count, head.
  - Same reset as fetch_unit.

Test Plan:
- Reset: hold `rst_n`=0 for 2 cycles, then release.
  - During reset: `newPC`=0x00003000, `imemReq`=0, `instValid`=0.
  - Cycle after release: `imemReq`=1, `imemAddr`=0x00003000.
- Zero-wait streaming: `imemAck` every cycle, `instReady`=1.
  - `instPC` = 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - `newPC` advances by 4 per cycle.
- Backpressure: `instReady`=0, zero-wait memory.
  - After 2 accepts, `imemReq`=0, `instValid`=1, `pc` frozen at 0x3008.
  - Raise `instReady`: heads 0x3000 and 0x3004 pop, then fetching resumes at 0x3008.
- Redirect during an outstanding read: 3-cycle ack latency, `redirect` to 0x00400000 one cycle after the request.
  - `imemAddr` holds 0x3000 until the stale ack.
  - Stale data never reaches `instValid`.
  - Next request is at 0x00400000.
- Redirect coincident with an ack while 1 entry is queued and `instReady`=0.
  - Both the queued and the arriving instruction are dropped.
  - `instValid`=0 next cycle; `newPC`=target.
- Reset while in S_DROP.
  - Next cycle: all outputs at reset values, `newPC`=0x00003000.
  - A later ack for the abandoned read is ignored.
